// File: rtl/fp_add_arbiter.sv
// Two-requester front end for one shared combinational FP adder: one operation in flight.
// Define FP_ADD_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module fp_add_arbiter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid0,
  input  logic         req_valid1,
  output logic         req_ready0,
  output logic         req_ready1,
  input  logic [W-1:0] req_a0,
  input  logic [W-1:0] req_b0,
  input  logic [W-1:0] req_a1,
  input  logic [W-1:0] req_b1,
  input  logic         req_sub0,
  input  logic         req_sub1,
  output logic         rsp_valid0,
  output logic         rsp_valid1,
  input  logic         rsp_ready0,
  input  logic         rsp_ready1,
  output logic [W-1:0] rsp_sum,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  output logic         add_cin,
  input  logic [W-1:0] add_sum,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t       state_q, state_d;
  logic [W-1:0] op_a_q, op_a_d;
  logic [W-1:0] op_b_q, op_b_d;
  logic [W-1:0] rsp_sum_q, rsp_sum_d;
  logic         owner_q, owner_d;
  logic         grant_valid;
  logic         grant_idx;
  logic [W-1:0] sel_b;
  logic         sel_sub;

`ifdef FP_ADD_ARB_RR_EN
  logic last_grant_q, last_grant_d;

  // On contention, favour whoever did not win last time.
  always_comb begin
    grant_valid = req_valid0 | req_valid1;
    if (req_valid0 && req_valid1) grant_idx = ~last_grant_q;
    else                          grant_idx = ~req_valid0;
  end
`else
  always_comb begin
    grant_valid = req_valid0 | req_valid1;
    grant_idx   = ~req_valid0;
  end
`endif

  assign sel_b   = grant_idx ? req_b1 : req_b0;
  assign sel_sub = grant_idx ? req_sub1 : req_sub0;

  always_comb begin
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    rsp_sum_d  = rsp_sum_q;
    owner_d    = owner_q;
    req_ready0 = 1'b0;
    req_ready1 = 1'b0;
`ifdef FP_ADD_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          req_ready0 = ~grant_idx;
          req_ready1 = grant_idx;
          op_a_d     = grant_idx ? req_a1 : req_a0;
          op_b_d     = {sel_b[W-1] ^ sel_sub, sel_b[W-2:0]};
          owner_d    = grant_idx;
          state_d    = ISSUE;
`ifdef FP_ADD_ARB_RR_EN
          last_grant_d = grant_idx;
`endif
        end
      end
      ISSUE: begin
        rsp_sum_d = add_sum;
        state_d   = RESP;
      end
      RESP: begin
        if (owner_q ? rsp_ready1 : rsp_ready0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_a_q    <= '0;
      op_b_q    <= '0;
      rsp_sum_q <= '0;
      owner_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      rsp_sum_q <= rsp_sum_d;
      owner_q   <= owner_d;
    end
  end

`ifdef FP_ADD_ARB_RR_EN
  // Reset value 1 so the first contended grant goes to requester 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant_q <= 1'b1;
    else        last_grant_q <= last_grant_d;
  end
`endif

  assign add_a      = op_a_q;
  assign add_b      = op_b_q;
  assign add_cin    = 1'b0;
  assign rsp_sum    = rsp_sum_q;
  assign rsp_valid0 = (state_q == RESP) && !owner_q;
  assign rsp_valid1 = (state_q == RESP) && owner_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter; a lookup-table stub stands in for the shared FP adder.
module tb_fp_add_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid0, req_valid1, req_ready0, req_ready1;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic        req_sub0, req_sub1;
  logic        rsp_valid0, rsp_valid1, rsp_ready0, rsp_ready1;
  logic [31:0] rsp_sum, add_a, add_b, add_sum;
  logic        add_cin, busy;
  int          vectors = 0;
  int          errors  = 0;

  always #5 clk = ~clk;

  fp_add_arbiter #(.W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid0(req_valid0), .req_valid1(req_valid1),
    .req_ready0(req_ready0), .req_ready1(req_ready1),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_sub0(req_sub0), .req_sub1(req_sub1),
    .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
    .rsp_ready0(rsp_ready0), .rsp_ready1(rsp_ready1),
    .rsp_sum(rsp_sum), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .busy(busy)
  );

  // Hand-computed sums for the operand pairs used below.
  always_comb begin
    case ({add_a, add_b})
      {32'h3F800000, 32'h3F800000}: add_sum = 32'h40000000;
      {32'h41200000, 32'hBF800000}: add_sum = 32'h41100000;
      {32'h3FC00000, 32'h3FC00000}: add_sum = 32'h40400000;
      {32'h00000000, 32'h00000000}: add_sum = 32'h00000000;
      default:                      add_sum = 32'hFFFFFFFF;
    endcase
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid0 = 0; req_valid1 = 0; rsp_ready0 = 0; rsp_ready1 = 0;
    req_a0 = 0; req_b0 = 0; req_a1 = 0; req_b1 = 0; req_sub0 = 0; req_sub1 = 0;
    #3;
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h exp 0", busy); end
    vectors++; if (rsp_valid0 !== 1'b0 || rsp_valid1 !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0b%0b exp 00", rsp_valid1, rsp_valid0); end
    vectors++; if (add_a !== 32'h0 || add_b !== 32'h0) begin errors++; $display("FAIL reset_ops got %08h %08h exp 0 0", add_a, add_b); end
    vectors++; if (rsp_sum !== 32'h0) begin errors++; $display("FAIL reset_sum got %08h exp 0", rsp_sum); end
    vectors++; if (add_cin !== 1'b0) begin errors++; $display("FAIL reset_cin got %0h exp 0", add_cin); end
    vectors++; if (req_ready0 !== 1'b0 || req_ready1 !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b%0b exp 00", req_ready1, req_ready0); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    $display("reset: done");
  endtask

  task automatic test_idle_hold();
    repeat (3) cyc();
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %0h exp 0", busy); end
    vectors++; if (rsp_valid0 !== 1'b0 || rsp_valid1 !== 1'b0) begin errors++; $display("FAIL idle_rsp_valid got %0b%0b exp 00", rsp_valid1, rsp_valid0); end
    $display("idle hold: no request, 3 cycles");
  endtask

  task automatic test_req0_add();
    req_valid0 = 1; req_a0 = 32'h3F800000; req_b0 = 32'h3F800000; req_sub0 = 0;
    #1;
    vectors++; if (req_ready0 !== 1'b1 || req_ready1 !== 1'b0) begin errors++; $display("FAIL r0_grant got %0b%0b exp 01", req_ready1, req_ready0); end
    cyc();
    req_valid0 = 0; req_a0 = 32'h12345678;
    vectors++; if (busy !== 1'b1 || rsp_valid0 !== 1'b0) begin errors++; $display("FAIL r0_issue busy/valid got %0b/%0b exp 1/0", busy, rsp_valid0); end
    vectors++; if (add_a !== 32'h3F800000 || add_b !== 32'h3F800000) begin errors++; $display("FAIL r0_issue_ops got %08h %08h exp 3f800000 3f800000", add_a, add_b); end
    cyc();
    vectors++; if (rsp_valid0 !== 1'b1 || rsp_valid1 !== 1'b0) begin errors++; $display("FAIL r0_resp_valid got %0b%0b exp 01", rsp_valid1, rsp_valid0); end
    vectors++; if (rsp_sum !== 32'h40000000) begin errors++; $display("FAIL r0_sum got %08h exp 40000000", rsp_sum); end
    rsp_ready0 = 1;
    cyc();
    rsp_ready0 = 0;
    vectors++; if (busy !== 1'b0 || rsp_valid0 !== 1'b0) begin errors++; $display("FAIL r0_done busy/valid got %0b/%0b exp 0/0", busy, rsp_valid0); end
    $display("req0 1.0+1.0 -> %08h", rsp_sum);
  endtask

  task automatic test_req1_sub();
    req_valid1 = 1; req_a1 = 32'h41200000; req_b1 = 32'h3F800000; req_sub1 = 1;
    #1;
    vectors++; if (req_ready1 !== 1'b1 || req_ready0 !== 1'b0) begin errors++; $display("FAIL r1_grant got %0b%0b exp 10", req_ready1, req_ready0); end
    cyc();
    req_valid1 = 0;
    vectors++; if (add_a !== 32'h41200000 || add_b !== 32'hBF800000) begin errors++; $display("FAIL r1_issue_ops got %08h %08h exp 41200000 bf800000", add_a, add_b); end
    vectors++; if (rsp_valid1 !== 1'b0) begin errors++; $display("FAIL r1_issue_valid got %0b exp 0", rsp_valid1); end
    cyc();
    vectors++; if (rsp_valid1 !== 1'b1 || rsp_valid0 !== 1'b0) begin errors++; $display("FAIL r1_resp_valid got %0b%0b exp 10", rsp_valid1, rsp_valid0); end
    vectors++; if (rsp_sum !== 32'h41100000) begin errors++; $display("FAIL r1_sum got %08h exp 41100000", rsp_sum); end
    rsp_ready0 = 1;
    cyc();
    rsp_ready0 = 0;
    vectors++; if (rsp_valid1 !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL r1_nonowner_ready got valid %0b busy %0b exp 1 1", rsp_valid1, busy); end
    rsp_ready1 = 1;
    cyc();
    rsp_ready1 = 0;
    vectors++; if (busy !== 1'b0 || rsp_valid1 !== 1'b0) begin errors++; $display("FAIL r1_done busy/valid got %0b/%0b exp 0/0", busy, rsp_valid1); end
    $display("req1 10.0-1.0 -> %08h", rsp_sum);
  endtask

  task automatic test_both_valid();
    int exp_idx;
    int ready1_seen;
    ready1_seen = 0;
    rst_n = 0; #1; rst_n = 1;
    req_a0 = 32'h3FC00000; req_b0 = 32'h3FC00000; req_sub0 = 0;
    req_a1 = 32'h3F800000; req_b1 = 32'h3F800000; req_sub1 = 0;
    req_valid0 = 1; req_valid1 = 1;
    for (int i = 0; i < 4; i++) begin
`ifdef FP_ADD_ARB_RR_EN
      exp_idx = i % 2;
`else
      exp_idx = 0;
`endif
      #1;
      if (req_ready1 === 1'b1) ready1_seen++;
      vectors++; if (req_ready0 !== (exp_idx == 0) || req_ready1 !== (exp_idx == 1)) begin errors++; $display("FAIL both_grant%0d got %0b%0b exp idx %0d", i, req_ready1, req_ready0, exp_idx); end
      cyc();
      if (req_ready1 === 1'b1) ready1_seen++;
      vectors++; if (req_ready0 !== 1'b0 || req_ready1 !== 1'b0) begin errors++; $display("FAIL both_issue_ready%0d got %0b%0b exp 00", i, req_ready1, req_ready0); end
      cyc();
      if (req_ready1 === 1'b1) ready1_seen++;
      vectors++; if (rsp_valid0 !== (exp_idx == 0) || rsp_valid1 !== (exp_idx == 1)) begin errors++; $display("FAIL both_rsp_valid%0d got %0b%0b exp idx %0d", i, rsp_valid1, rsp_valid0, exp_idx); end
      vectors++; if (rsp_sum !== ((exp_idx == 1) ? 32'h40000000 : 32'h40400000)) begin errors++; $display("FAIL both_sum%0d got %08h exp idx %0d", i, rsp_sum, exp_idx); end
      $display("both valid op %0d: owner %0d sum %08h", i, exp_idx, rsp_sum);
      rsp_ready0 = 1; rsp_ready1 = 1;
      cyc();
      rsp_ready0 = 0; rsp_ready1 = 0;
    end
    req_valid0 = 0; req_valid1 = 0;
`ifndef FP_ADD_ARB_RR_EN
    vectors++; if (ready1_seen != 0) begin errors++; $display("FAIL fixed_ready1 got %0d highs exp 0", ready1_seen); end
`endif
    cyc();
  endtask

  task automatic test_backpressure();
    req_valid0 = 1; req_a0 = 32'h3F800000; req_b0 = 32'h3F800000; req_sub0 = 0;
    cyc();
    req_valid0 = 0;
    cyc();
    req_valid1 = 1; rsp_ready1 = 1;
    for (int i = 0; i < 5; i++) begin
      vectors++; if (rsp_valid0 !== 1'b1 || rsp_sum !== 32'h40000000) begin errors++; $display("FAIL bp_hold%0d got valid %0b sum %08h exp 1 40000000", i, rsp_valid0, rsp_sum); end
      vectors++; if (req_ready0 !== 1'b0 || req_ready1 !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL bp_ctrl%0d got rdy %0b%0b busy %0b exp 00 1", i, req_ready1, req_ready0, busy); end
      cyc();
    end
    req_valid1 = 0; rsp_ready1 = 0; rsp_ready0 = 1;
    cyc();
    rsp_ready0 = 0;
    vectors++; if (busy !== 1'b0 || rsp_valid0 !== 1'b0) begin errors++; $display("FAIL bp_release got busy %0b valid %0b exp 0 0", busy, rsp_valid0); end
    $display("backpressure: 5 stall cycles then release");
  endtask

  task automatic test_reset_mid_issue();
    req_valid0 = 1; req_a0 = 32'h3F800000; req_b0 = 32'h3F800000; req_sub0 = 0;
    cyc();
    req_valid0 = 0;
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_pre_busy got %0b exp 1", busy); end
    rst_n = 0; #1;
    vectors++; if (busy !== 1'b0 || rsp_valid0 !== 1'b0 || rsp_valid1 !== 1'b0) begin errors++; $display("FAIL rmid_state got busy %0b valid %0b%0b exp 0 00", busy, rsp_valid1, rsp_valid0); end
    vectors++; if (add_a !== 32'h0 || add_b !== 32'h0 || rsp_sum !== 32'h0) begin errors++; $display("FAIL rmid_regs got %08h %08h %08h exp 0", add_a, add_b, rsp_sum); end
    #1; rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      vectors++; if (rsp_valid0 !== 1'b0 || rsp_valid1 !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_quiet%0d got valid %0b%0b busy %0b exp 00 0", i, rsp_valid1, rsp_valid0, busy); end
    end
    req_valid1 = 1; req_a1 = 32'h41200000; req_b1 = 32'h3F800000; req_sub1 = 1;
    cyc();
    req_valid1 = 0;
    cyc();
    vectors++; if (rsp_valid1 !== 1'b1 || rsp_sum !== 32'h41100000) begin errors++; $display("FAIL rmid_next got valid %0b sum %08h exp 1 41100000", rsp_valid1, rsp_sum); end
    rsp_ready1 = 1;
    cyc();
    rsp_ready1 = 0;
    $display("reset mid-issue: discarded, next op sum %08h", rsp_sum);
  endtask

  initial begin
    // Watchdog so the run always ends on its own.
    #100000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    @(negedge clk);
    test_idle_hold();
    test_req0_add();
    test_req1_sub();
    test_both_valid();
    test_backpressure();
    test_reset_mid_issue();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
